ball_motion_generator: RTL and testbench
========================================

Name: ball_motion_generator

Overview:
- Consumer end of the ball velocity code interface: takes the horizontal codes (CX0, CX1, X2) and vertical codes (Y0, Y1, Y2) from ball hit/motion control.
- Integrates the codes once per frame into a ball position and generates BALL_DISPLAY from raster counts.
- BALL_DISPLAY feeds back into paddle, brick and boundary hit detection and into video mixing.

Parameters:
- POS_W, 9, width of position and raster counts.
- BALL_SIZE, 4, ball width and height in pixels.
- SERVE_X, 9'd128, horizontal position loaded while serving.
- SERVE_Y, 9'd160, vertical position loaded while serving.

Ports:
- CLK_DRV  input  1  system clock; all logic on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- H_CNT  input  POS_W  current raster horizontal count.
- V_CNT  input  POS_W  current raster vertical count.
- VSYNC  input  1  level; a rising edge starts the per-frame position update.
- SERVE_WAIT  input  1  high = ball parked at serve position and hidden.
- CX0, CX1  input  1 each  horizontal speed magnitude, {CX1,CX0} = 0..3 px/frame.
- X2  input  1  horizontal direction: 1 = +X (right), 0 = −X.
- Y0, Y1  input  1 each  vertical speed magnitude, {Y1,Y0} = 0..3 px/frame.
- Y2  input  1  vertical direction: 1 = +Y (down), 0 = −Y.
- BALL_H  output  POS_W  ball left edge.
- BALL_V  output  POS_W  ball top edge.
- BALL_DISPLAY  output  1  ball pixel active (registered).
- UPDATE_DONE  output  1  one-cycle pulse when the frame update completes.

Behaviour:
- Reset values: BALL_H = SERVE_X, BALL_V = SERVE_Y, BALL_DISPLAY = 0, UPDATE_DONE = 0, FSM = IDLE, VSYNC edge register = 0.
- VSYNC edge detection: VSYNC is registered; rise = VSYNC & ~VSYNC_q. Edge-to-LATCH latency is 1 cycle.
- FSM states: IDLE, LATCH, STEP_H, STEP_V.
  - IDLE → LATCH on rise.
  - LATCH: sample all six codes into holding registers. This protects the update from code changes mid-update.
  - STEP_H: BALL_H ← BALL_H ± hmag.
  - STEP_V: BALL_V ← BALL_V ± vmag; pulse UPDATE_DONE; → IDLE.
  - Total: BALL_H updates 3 cycles after the VSYNC edge, BALL_V updates 4 cycles after.
- Arithmetic: unsigned modulo 2^POS_W; wrap-around is allowed. Wall and top handling is the controller's job, via direction flips.
- Magnitude 0 leaves the axis unchanged but still runs through the states.
- A VSYNC rise in any state other than IDLE is ignored. No queuing.
- SERVE_WAIT high, any cycle, overrides everything:
  - next cycle BALL_H = SERVE_X, BALL_V = SERVE_Y, FSM = IDLE, BALL_DISPLAY = 0;
  - any update in progress is aborted with no UPDATE_DONE.
  - Normal operation resumes at the first VSYNC rise after SERVE_WAIT falls.
- BALL_DISPLAY, 1-cycle latency from H_CNT/V_CNT: registered ((H_CNT − BALL_H) mod 2^POS_W < BALL_SIZE) & ((V_CNT − BALL_V) mod 2^POS_W < BALL_SIZE) & ~SERVE_WAIT.
- Async RESET asserted mid-update: immediately returns all state to reset values.

Optional Feature:
- Macro: BALL_HALF_STEP_EN.
- Defined:
  - A frame-parity flop toggles on each completed update; reset value 0.
  - Magnitude code 1 (either axis) moves 1 px only when parity is 1, i.e. 0.5 px/frame average.
  - Codes 0, 2 and 3 are unchanged.
  - SERVE_WAIT clears parity to 0.
- Not defined: code 1 = 1 px every frame, and the parity flop is absent.

Decomposition:
- Package breakout_pkg:
  - typedef pos_t (logic [POS_W-1:0]);
  - enum motion_state_t {IDLE, LATCH, STEP_H, STEP_V};
  - constants SERVE_X_DEF and SERVE_Y_DEF.
- Sub-module ball_axis_step, instantiated twice (H and V):
  - ports: CLK_DRV, RESET, load, serve value, step enable, dir, mag, half-step parity, pos out;
  - holds one position register plus the ± magnitude adder.

Test Plan:
- Reset, then release with SERVE_WAIT=0 → BALL_H=128, BALL_V=160, BALL_DISPLAY=0, no UPDATE_DONE until the first VSYNC rise.
- Codes CX=3, X2=1, Y=2, Y2=0, one VSYNC rise → 3 cycles later BALL_H=131; 4 cycles later BALL_V=158; UPDATE_DONE pulses once.
- BALL_H=510, CX=3, X2=1 → BALL_H=1 after the update (wrap); BALL_V=1, Y=2, Y2=0 → BALL_V=511.
- Raster sweep with BALL_H=131, BALL_V=158 → BALL_DISPLAY high, one cycle delayed, exactly for H_CNT 131..134 × V_CNT 158..161 (16 pixels per frame).
- SERVE_WAIT pulsed during STEP_H → next cycle position is 128/160, no UPDATE_DONE; the codes changing in the same frame do not affect position.
- With BALL_HALF_STEP_EN, CX=1, X2=1, four frames from BALL_H=128 → positions 128, 129, 129, 130. Without the macro → 129, 130, 131, 132.

Source files
------------

// File: rtl/breakout_pkg.sv
// Shared types and defaults for the breakout ball motion path.
package breakout_pkg;

    localparam int unsigned POS_W         = 9;
    localparam int unsigned BALL_SIZE_DEF = 4;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        STEP_H,
        STEP_V
    } motion_state_t;

    localparam pos_t SERVE_X_DEF = 9'd128;
    localparam pos_t SERVE_Y_DEF = 9'd160;

endpackage

// File: rtl/ball_axis_step.sv
// One ball axis: position register plus signed-by-direction magnitude step.
// Honours BALL_HALF_STEP_EN: magnitude code 1 only moves on odd-parity frames.
module ball_axis_step #(
    parameter int unsigned      POS_W     = breakout_pkg::POS_W,
    parameter logic [POS_W-1:0] RESET_VAL = '0
) (
    input  logic             CLK_DRV,
    input  logic             RESET,
    input  logic             load,
    input  logic [POS_W-1:0] serve_val,
    input  logic             step_en,
    input  logic             dir,
    input  logic [1:0]       mag,
    input  logic             parity,
    output logic [POS_W-1:0] pos
);
    import breakout_pkg::*;

    logic [1:0]       eff_mag;
    logic [POS_W-1:0] delta;

`ifdef BALL_HALF_STEP_EN
    assign eff_mag = ((mag == 2'd1) && !parity) ? 2'd0 : mag;
`else
    logic unused_parity;
    assign unused_parity = parity;
    assign eff_mag       = mag;
`endif

    assign delta = POS_W'(eff_mag);

    // Serve load has priority over stepping; arithmetic wraps modulo 2^POS_W.
    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            pos <= RESET_VAL;
        end else if (load) begin
            pos <= serve_val;
        end else if (step_en) begin
            pos <= dir ? (pos + delta) : (pos - delta);
        end
    end

endmodule

// File: rtl/ball_motion_generator.sv
// Integrates per-frame ball velocity codes into a position and draws the ball.
// Optional BALL_HALF_STEP_EN adds a frame-parity flop for 0.5 px/frame speed.
module ball_motion_generator #(
    parameter int unsigned      POS_W     = breakout_pkg::POS_W,
    parameter int unsigned      BALL_SIZE = breakout_pkg::BALL_SIZE_DEF,
    parameter logic [POS_W-1:0] SERVE_X   = POS_W'(breakout_pkg::SERVE_X_DEF),
    parameter logic [POS_W-1:0] SERVE_Y   = POS_W'(breakout_pkg::SERVE_Y_DEF)
) (
    input  logic             CLK_DRV,
    input  logic             RESET,
    input  logic [POS_W-1:0] H_CNT,
    input  logic [POS_W-1:0] V_CNT,
    input  logic             VSYNC,
    input  logic             SERVE_WAIT,
    input  logic             CX0,
    input  logic             CX1,
    input  logic             X2,
    input  logic             Y0,
    input  logic             Y1,
    input  logic             Y2,
    output logic [POS_W-1:0] BALL_H,
    output logic [POS_W-1:0] BALL_V,
    output logic             BALL_DISPLAY,
    output logic             UPDATE_DONE
);
    import breakout_pkg::*;

    motion_state_t    state;
    logic             vsync_q;
    logic             rise;
    logic [1:0]       h_mag;
    logic [1:0]       v_mag;
    logic             h_dir;
    logic             v_dir;
    logic             parity;
    logic [POS_W-1:0] h_off;
    logic [POS_W-1:0] v_off;

    assign rise = VSYNC & ~vsync_q;

    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= VSYNC;
        end
    end

    // Frame update sequencer; codes are frozen in LATCH so mid-update changes are harmless.
    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            h_mag       <= 2'd0;
            v_mag       <= 2'd0;
            h_dir       <= 1'b0;
            v_dir       <= 1'b0;
            UPDATE_DONE <= 1'b0;
        end else begin
            UPDATE_DONE <= 1'b0;
            if (SERVE_WAIT) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) state <= LATCH;
                    end
                    LATCH: begin
                        h_mag <= {CX1, CX0};
                        h_dir <= X2;
                        v_mag <= {Y1, Y0};
                        v_dir <= Y2;
                        state <= STEP_H;
                    end
                    STEP_H: begin
                        state <= STEP_V;
                    end
                    STEP_V: begin
                        UPDATE_DONE <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef BALL_HALF_STEP_EN
    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            parity <= 1'b0;
        end else if (SERVE_WAIT) begin
            parity <= 1'b0;
        end else if (state == STEP_V) begin
            parity <= ~parity;
        end
    end
`else
    assign parity = 1'b0;
`endif

    ball_axis_step #(
        .POS_W     (POS_W),
        .RESET_VAL (SERVE_X)
    ) u_axis_h (
        .CLK_DRV   (CLK_DRV),
        .RESET     (RESET),
        .load      (SERVE_WAIT),
        .serve_val (SERVE_X),
        .step_en   (state == STEP_H),
        .dir       (h_dir),
        .mag       (h_mag),
        .parity    (parity),
        .pos       (BALL_H)
    );

    ball_axis_step #(
        .POS_W     (POS_W),
        .RESET_VAL (SERVE_Y)
    ) u_axis_v (
        .CLK_DRV   (CLK_DRV),
        .RESET     (RESET),
        .load      (SERVE_WAIT),
        .serve_val (SERVE_Y),
        .step_en   (state == STEP_V),
        .dir       (v_dir),
        .mag       (v_mag),
        .parity    (parity),
        .pos       (BALL_V)
    );

    // Modular offsets make the ball draw correctly across the wrap point.
    assign h_off = H_CNT - BALL_H;
    assign v_off = V_CNT - BALL_V;

    always_ff @(posedge CLK_DRV or posedge RESET) begin
        if (RESET) begin
            BALL_DISPLAY <= 1'b0;
        end else begin
            BALL_DISPLAY <= (h_off < POS_W'(BALL_SIZE)) && (v_off < POS_W'(BALL_SIZE)) && !SERVE_WAIT;
        end
    end

endmodule

// File: tb/tb_ball_motion_generator.sv
// Directed self-checking bench for ball_motion_generator (BALL_HALF_STEP_EN aware).
module tb_ball_motion_generator;

    logic       CLK_DRV = 1'b0;
    logic       RESET;
    logic [8:0] H_CNT;
    logic [8:0] V_CNT;
    logic       VSYNC;
    logic       SERVE_WAIT;
    logic       CX0, CX1, X2, Y0, Y1, Y2;
    logic [8:0] BALL_H;
    logic [8:0] BALL_V;
    logic       BALL_DISPLAY;
    logic       UPDATE_DONE;

    int checks = 0;
    int fails  = 0;

    always #5 CLK_DRV = ~CLK_DRV;

    ball_motion_generator dut (
        .CLK_DRV      (CLK_DRV),
        .RESET        (RESET),
        .H_CNT        (H_CNT),
        .V_CNT        (V_CNT),
        .VSYNC        (VSYNC),
        .SERVE_WAIT   (SERVE_WAIT),
        .CX0          (CX0),
        .CX1          (CX1),
        .X2           (X2),
        .Y0           (Y0),
        .Y1           (Y1),
        .Y2           (Y2),
        .BALL_H       (BALL_H),
        .BALL_V       (BALL_V),
        .BALL_DISPLAY (BALL_DISPLAY),
        .UPDATE_DONE  (UPDATE_DONE)
    );

    task automatic tick();
        @(posedge CLK_DRV);
        #1;
    endtask

    task automatic set_codes(input logic [1:0] cx, input logic x2, input logic [1:0] y, input logic y2);
        {CX1, CX0} = cx;
        X2         = x2;
        {Y1, Y0}   = y;
        Y2         = y2;
    endtask

    task automatic frame(input logic [1:0] cx, input logic x2, input logic [1:0] y, input logic y2);
        set_codes(cx, x2, y, y2);
        VSYNC = 1'b1;
        repeat (6) tick();
        VSYNC = 1'b0;
        tick();
    endtask

    task automatic serve_pulse();
        SERVE_WAIT = 1'b1;
        tick();
        SERVE_WAIT = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1; VSYNC = 1'b0; SERVE_WAIT = 1'b0;
        H_CNT = 9'd0; V_CNT = 9'd0;
        set_codes(2'd0, 1'b0, 2'd0, 1'b0);
        tick(); tick();
        checks++; if (BALL_H !== 9'd128) begin fails++; $display("FAIL reset_h: got %0d expected 128", BALL_H); end
        checks++; if (BALL_V !== 9'd160) begin fails++; $display("FAIL reset_v: got %0d expected 160", BALL_V); end
        checks++; if (BALL_DISPLAY !== 1'b0) begin fails++; $display("FAIL reset_disp: got %b expected 0", BALL_DISPLAY); end
        checks++; if (UPDATE_DONE !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", UPDATE_DONE); end
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (UPDATE_DONE !== 1'b0 || BALL_H !== 9'd128 || BALL_V !== 9'd160) begin
                fails++; $display("FAIL idle_after_reset: got done=%b h=%0d v=%0d expected done=0 h=128 v=160", UPDATE_DONE, BALL_H, BALL_V);
            end
        end
    endtask

    task automatic test_update();
        logic [8:0] eh, ev;
        set_codes(2'd3, 1'b1, 2'd2, 1'b0);
        VSYNC = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            eh = (k < 3) ? 9'd128 : 9'd131;
            ev = (k < 4) ? 9'd160 : 9'd158;
            checks++; if (BALL_H !== eh) begin fails++; $display("FAIL update_h cycle %0d: got %0d expected %0d", k, BALL_H, eh); end
            checks++; if (BALL_V !== ev) begin fails++; $display("FAIL update_v cycle %0d: got %0d expected %0d", k, BALL_V, ev); end
            checks++; if (UPDATE_DONE !== (k == 4)) begin fails++; $display("FAIL update_done cycle %0d: got %b expected %b", k, UPDATE_DONE, (k == 4)); end
        end
        VSYNC = 1'b0;
        tick();
    endtask

    task automatic test_display();
        int   hits;
        logic exp;
        hits = 0;
        H_CNT = 9'd131; V_CNT = 9'd158;
        #2;
        checks++; if (BALL_DISPLAY !== 1'b0) begin fails++; $display("FAIL disp_latency: got %b expected 0 before edge", BALL_DISPLAY); end
        tick();
        checks++; if (BALL_DISPLAY !== 1'b1) begin fails++; $display("FAIL disp_after_edge: got %b expected 1", BALL_DISPLAY); end
        for (int v = 156; v <= 163; v++) begin
            for (int h = 129; h <= 136; h++) begin
                H_CNT = 9'(h); V_CNT = 9'(v);
                tick();
                exp = (h >= 131 && h <= 134 && v >= 158 && v <= 161);
                if (BALL_DISPLAY === 1'b1) hits++;
                checks++; if (BALL_DISPLAY !== exp) begin fails++; $display("FAIL disp h=%0d v=%0d: got %b expected %b", h, v, BALL_DISPLAY, exp); end
            end
        end
        checks++; if (hits != 16) begin fails++; $display("FAIL disp_count: got %0d expected 16", hits); end
        H_CNT = 9'd0; V_CNT = 9'd0;
        tick();
    endtask

    task automatic test_wrap();
        serve_pulse();
        checks++; if (BALL_H !== 9'd128 || BALL_V !== 9'd160) begin fails++; $display("FAIL wrap_start: got %0d/%0d expected 128/160", BALL_H, BALL_V); end
        for (int i = 0; i < 65; i++) frame(2'd2, 1'b0, (i < 53) ? 2'd3 : 2'd0, 1'b0);
        checks++; if (BALL_H !== 9'd510) begin fails++; $display("FAIL wrap_pre_h: got %0d expected 510", BALL_H); end
        checks++; if (BALL_V !== 9'd1) begin fails++; $display("FAIL wrap_pre_v: got %0d expected 1", BALL_V); end
        frame(2'd3, 1'b1, 2'd2, 1'b0);
        checks++; if (BALL_H !== 9'd1) begin fails++; $display("FAIL wrap_h: got %0d expected 1", BALL_H); end
        checks++; if (BALL_V !== 9'd511) begin fails++; $display("FAIL wrap_v: got %0d expected 511", BALL_V); end
    endtask

    task automatic test_serve_abort();
        set_codes(2'd3, 1'b1, 2'd3, 1'b1);
        VSYNC = 1'b1;
        tick(); tick();
        set_codes(2'd2, 1'b0, 2'd1, 1'b0);
        SERVE_WAIT = 1'b1;
        tick();
        checks++; if (BALL_H !== 9'd128 || BALL_V !== 9'd160) begin fails++; $display("FAIL abort_pos: got %0d/%0d expected 128/160", BALL_H, BALL_V); end
        checks++; if (UPDATE_DONE !== 1'b0 || BALL_DISPLAY !== 1'b0) begin fails++; $display("FAIL abort_flags: got done=%b disp=%b expected 0/0", UPDATE_DONE, BALL_DISPLAY); end
        SERVE_WAIT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (UPDATE_DONE !== 1'b0 || BALL_H !== 9'd128 || BALL_V !== 9'd160) begin
                fails++; $display("FAIL abort_hold cycle %0d: got done=%b h=%0d v=%0d expected 0/128/160", i, UPDATE_DONE, BALL_H, BALL_V);
            end
        end
        VSYNC = 1'b0;
        tick();
        SERVE_WAIT = 1'b1; VSYNC = 1'b1;
        tick(); tick();
        SERVE_WAIT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (UPDATE_DONE !== 1'b0 || BALL_H !== 9'd128) begin
                fails++; $display("FAIL serve_vsync_ignored cycle %0d: got done=%b h=%0d expected 0/128", i, UPDATE_DONE, BALL_H);
            end
        end
        VSYNC = 1'b0;
        H_CNT = 9'd129; V_CNT = 9'd161; SERVE_WAIT = 1'b1;
        tick();
        checks++; if (BALL_DISPLAY !== 1'b0) begin fails++; $display("FAIL serve_hidden: got %b expected 0", BALL_DISPLAY); end
        SERVE_WAIT = 1'b0;
        tick();
        checks++; if (BALL_DISPLAY !== 1'b1) begin fails++; $display("FAIL serve_visible: got %b expected 1", BALL_DISPLAY); end
        H_CNT = 9'd0; V_CNT = 9'd0;
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        set_codes(2'd2, 1'b1, 2'd3, 1'b1);
        VSYNC = 1'b1;
        tick();
        VSYNC = 1'b0;
        tick();
        VSYNC = 1'b1;
        tick();
        VSYNC = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (UPDATE_DONE === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin fails++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
        checks++; if (BALL_H !== 9'd130) begin fails++; $display("FAIL b2b_h: got %0d expected 130", BALL_H); end
        checks++; if (BALL_V !== 9'd163) begin fails++; $display("FAIL b2b_v: got %0d expected 163", BALL_V); end
    endtask

    task automatic test_half_step();
        logic [8:0] exp_h [4];
`ifdef BALL_HALF_STEP_EN
        exp_h = '{9'd128, 9'd129, 9'd129, 9'd130};
`else
        exp_h = '{9'd129, 9'd130, 9'd131, 9'd132};
`endif
        serve_pulse();
        for (int i = 0; i < 4; i++) begin
            frame(2'd1, 1'b1, 2'd0, 1'b0);
            checks++; if (BALL_H !== exp_h[i]) begin fails++; $display("FAIL half_step frame %0d: got %0d expected %0d", i, BALL_H, exp_h[i]); end
            checks++; if (BALL_V !== 9'd160) begin fails++; $display("FAIL half_step_v frame %0d: got %0d expected 160", i, BALL_V); end
        end
    endtask

    task automatic test_async_reset();
        set_codes(2'd3, 1'b1, 2'd3, 1'b1);
        VSYNC = 1'b1;
        tick(); tick();
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (BALL_H !== 9'd128 || BALL_V !== 9'd160) begin fails++; $display("FAIL async_reset_pos: got %0d/%0d expected 128/160", BALL_H, BALL_V); end
        checks++; if (UPDATE_DONE !== 1'b0 || BALL_DISPLAY !== 1'b0) begin fails++; $display("FAIL async_reset_flags: got done=%b disp=%b expected 0/0", UPDATE_DONE, BALL_DISPLAY); end
        tick();
        RESET = 1'b0;
        VSYNC = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (UPDATE_DONE !== 1'b0 || BALL_H !== 9'd128) begin
                fails++; $display("FAIL post_reset_idle cycle %0d: got done=%b h=%0d expected 0/128", i, UPDATE_DONE, BALL_H);
            end
        end
        frame(2'd3, 1'b1, 2'd2, 1'b0);
        checks++; if (BALL_H !== 9'd131 || BALL_V !== 9'd158) begin fails++; $display("FAIL post_reset_frame: got %0d/%0d expected 131/158", BALL_H, BALL_V); end
    endtask

    initial begin
        test_reset();
        test_update();
        test_display();
        test_wrap();
        test_serve_abort();
        test_back_to_back();
        test_half_step();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
